cdb_receiver: RTL
=================

// Module: cdb_receiver
// PURPOSE
//  Receiving end of the common data bus (CDB): consumes one CDB_PACKET per cycle.
//  - Tracks per-physical-tag ready bits and result values.
//  - Serves two dispatch-side operand lookups.
//  - Runs the mispredict recovery / halt FSM: flush pulse, then fetch redirect.
//  - Sits between the CDB driver and the dispatch/fetch stages.
// PARAMETERS
//  PRF_SIZE      64  physical tags; tag 0 = zero register
//  TAG_W         $clog2(PRF_SIZE)  tag width
//  XLEN          32  data/PC width
//  FLUSH_CYCLES  2   cycles flush_out held high on a mispredict (>=1)
// PORTS
//  clock           input   1      single clock, rising edge
//  reset           input   1      asynchronous, active-low reset
//  cdb_valid       input   1      cdb_packet_in carries a broadcast this cycle
//  cdb_packet_in   input   CDB_PACKET  reg_tag{tag,valid}, no_output, reg_value, correct_PC, PC, correct_predict, take_branch, halt, illegal
//  alloc_valid     input   1      dispatch allocates alloc_tag (marks it not-ready)
//  alloc_tag       input   TAG_W
//  rd_tag[2]       input   2xTAG_W  operand lookup tags
//  rd_ready[2]     output  2      tag result available
//  rd_value[2]     output  2xXLEN   result value (0 when not ready)
//  flush_out       output  1      squash younger work
//  redirect_valid  output  1      one-cycle fetch redirect pulse
//  redirect_pc     output  XLEN   target for redirect_valid
//  halted          output  1      sticky; halt or illegal retired on CDB
//  busy            output  1      FSM not in IDLE
// BEHAVIOUR
//  Reset (async, reset==0):
//   - every ready bit = 1; every value = 0; FSM -> IDLE.
//   - flush_out=0, redirect_valid=0, redirect_pc=0, halted=0, busy=0.
//  Table write (posedge), when cdb_valid & reg_tag.valid & tag!=0:
//   ready[tag] <= 1; value[tag] <= reg_value.
//   - no_output=1 or reg_tag.valid=0: no table write.
//  Allocate: alloc_valid & alloc_tag!=0 -> ready <= 0, value unchanged.
//   - Same tag allocated and written in one cycle: allocate wins (ready=0).
//  Tag 0: always ready=1, value=0; writes and allocates ignored.
//  Lookups: combinational from stored state.
//  Recovery FSM (states IDLE, FLUSH, REDIRECT, HALT):
//   IDLE -> FLUSH: on cdb_valid & !correct_predict & !halt & !illegal.
//    - Latch correct_PC into redirect_pc; load counter = FLUSH_CYCLES-1.
//   FLUSH: flush_out=1; counter decrements; at 0 -> REDIRECT.
//   REDIRECT: redirect_valid=1 for exactly one cycle, flush_out=0 -> IDLE.
//   any state -> HALT: cdb_valid & (halt|illegal).
//    - HALT has priority over a mispredict in the same packet.
//   HALT: absorbing until reset; halted=1, flush_out=0, redirect_valid=0; table still updates.
//   Mispredicts arriving while busy: no new recovery, redirect_pc not overwritten;
//    table updates still occur.
//  Latency: mispredict on CDB at cycle N -> flush_out cycles N+1..N+FLUSH_CYCLES;
//   redirect_valid at N+FLUSH_CYCLES+1.
//  busy=1 in FLUSH and REDIRECT only.
//  Reset mid-recovery: immediate return to reset values; no redirect emitted.
// CONFIGURATION
//  CDB_BYPASS_EN defined:
//   - rd_tag matching a same-cycle qualifying CDB write (tag!=0) returns
//     rd_ready=1, rd_value=reg_value combinationally.
//   - A same-cycle allocate of that tag suppresses the bypass.
//  CDB_BYPASS_EN undefined: lookups see the written value one cycle after the broadcast.
// STRUCTURE
//  sys_defs.svh:
//   - CDB_PACKET is reused unchanged.
//   - RECOV_STATE enum {IDLE,FLUSH,REDIRECT,HALT} and PRF_SIZE are added to the shared package.
//  Sub-module cdb_ready_table: ready/value arrays, alloc/write priority, lookup (+bypass).
//  The top level holds the FSM and counter.
// TESTING
//  1 Reset, then rd_tag={5,0} -> rd_ready=2'b11, rd_value={0,0}.
//  2 alloc tag 5; next cycle CDB tag 5, valid=1, value 0xDEAD_BEEF -> ready 0, then 1 with value 0xDEADBEEF.
//    - With CDB_BYPASS_EN, the lookup in the broadcast cycle already returns 0xDEADBEEF.
//  3 Mispredict, correct_PC=0x0000_0100, FLUSH_CYCLES=2 -> flush_out high 2 cycles,
//    then redirect_valid one cycle with redirect_pc=0x100, busy low after.
//  4 Second mispredict, correct_PC=0x200, during FLUSH -> ignored; redirect_pc stays 0x100.
//  5 Same-cycle alloc tag 7 + CDB write tag 7 -> rd_ready[7]=0; CDB write to tag 0 -> value stays 0.
//  6 Packet halt=1 with correct_predict=0 -> HALT, halted=1, no flush/redirect.
//    - Reset (reset=0) mid-FLUSH -> all outputs at reset values immediately.

Source files
------------

// File: rtl/cdb_receiver_pkg.sv
// Shared CDB receiver types: packet layout, recovery state encoding and sizing constants.
package cdb_receiver_pkg;

    localparam int unsigned PRF_SIZE     = 64;
    localparam int unsigned TAG_W        = $clog2(PRF_SIZE);
    localparam int unsigned XLEN         = 32;
    localparam int unsigned FLUSH_CYCLES = 2;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             valid;
    } PRF_TAG;

    typedef struct packed {
        PRF_TAG          reg_tag;
        logic            no_output;
        logic [XLEN-1:0] reg_value;
        logic [XLEN-1:0] correct_PC;
        logic [XLEN-1:0] PC;
        logic            correct_predict;
        logic            take_branch;
        logic            halt;
        logic            illegal;
    } CDB_PACKET;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } RECOV_STATE;

endpackage

// File: rtl/cdb_receiver_if.sv
// CDB receiver bus bundle: broadcast in, allocate, operand lookups, recovery outputs.
interface cdb_receiver_if;
    import cdb_receiver_pkg::*;

    logic                       cdb_valid;
    CDB_PACKET                  cdb_packet_in;
    logic                       alloc_valid;
    logic [TAG_W-1:0]           alloc_tag;
    logic [1:0][TAG_W-1:0]      rd_tag;
    logic [1:0]                 rd_ready;
    logic [1:0][XLEN-1:0]       rd_value;
    logic                       flush_out;
    logic                       redirect_valid;
    logic [XLEN-1:0]            redirect_pc;
    logic                       halted;
    logic                       busy;

    modport master (
        output cdb_valid, cdb_packet_in, alloc_valid, alloc_tag, rd_tag,
        input  rd_ready, rd_value, flush_out, redirect_valid, redirect_pc, halted, busy
    );

    modport slave (
        input  cdb_valid, cdb_packet_in, alloc_valid, alloc_tag, rd_tag,
        output rd_ready, rd_value, flush_out, redirect_valid, redirect_pc, halted, busy
    );

endinterface

// File: rtl/cdb_receiver_ready_table.sv
// Per-tag ready/value storage with allocate-over-write priority and two lookup ports.
// Optional same-cycle write bypass on the lookups when CDB_BYPASS_EN is defined.
module cdb_receiver_ready_table
    import cdb_receiver_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [XLEN-1:0]       wr_value,
    input  logic                  alloc_en,
    input  logic [TAG_W-1:0]      alloc_tag,
    input  logic [1:0][TAG_W-1:0] rd_tag,
    output logic [1:0]            rd_ready,
    output logic [1:0][XLEN-1:0]  rd_value
);

    logic [PRF_SIZE-1:0] ready_q;
    logic [XLEN-1:0]     value_q [PRF_SIZE];

    // Entry 0 is never written, so it holds its reset state (ready, zero) forever.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_q <= '1;
            for (int i = 0; i < PRF_SIZE; i++) begin
                value_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < PRF_SIZE; i++) begin
                if (alloc_en && (alloc_tag == TAG_W'(i))) begin
                    ready_q[i] <= 1'b0;
                end else if (wr_en && (wr_tag == TAG_W'(i))) begin
                    ready_q[i] <= 1'b1;
                end
                if (wr_en && (wr_tag == TAG_W'(i))) begin
                    value_q[i] <= wr_value;
                end
            end
        end
    end

    always_comb begin
        rd_ready = '0;
        rd_value = '0;
        for (int p = 0; p < 2; p++) begin
            rd_ready[p] = ready_q[rd_tag[p]];
            rd_value[p] = ready_q[rd_tag[p]] ? value_q[rd_tag[p]] : '0;
`ifdef CDB_BYPASS_EN
            if (wr_en && (rd_tag[p] == wr_tag) && !(alloc_en && (alloc_tag == wr_tag))) begin
                rd_ready[p] = 1'b1;
                rd_value[p] = wr_value;
            end
`endif
        end
    end

endmodule

// File: rtl/cdb_receiver.sv
// CDB receiving end: tag scoreboard plus mispredict recovery / halt FSM.
// Build option: CDB_BYPASS_EN forwards same-cycle CDB writes to the lookups.
module cdb_receiver
    import cdb_receiver_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    cdb_receiver_if.slave  bus
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    CDB_PACKET        pkt;
    logic             wr_en;
    logic             alloc_en;
    logic             halt_ev;
    logic             mispredict;

    RECOV_STATE       state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [XLEN-1:0]  pc_q, pc_n;
    logic             flush_q, flush_n;
    logic             redir_q, redir_n;
    logic             halted_q, halted_n;
    logic             busy_q, busy_n;
    logic             unused_pkt;

    assign pkt        = bus.cdb_packet_in;
    assign wr_en      = bus.cdb_valid & pkt.reg_tag.valid & ~pkt.no_output
                        & (pkt.reg_tag.tag != '0);
    assign alloc_en   = bus.alloc_valid & (bus.alloc_tag != '0);
    assign halt_ev    = bus.cdb_valid & (pkt.halt | pkt.illegal);
    assign mispredict = bus.cdb_valid & ~pkt.correct_predict & ~pkt.halt & ~pkt.illegal;
    assign unused_pkt = ^{pkt.PC, pkt.take_branch};

    cdb_receiver_ready_table u_table (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_tag    (pkt.reg_tag.tag),
        .wr_value  (pkt.reg_value),
        .alloc_en  (alloc_en),
        .alloc_tag (bus.alloc_tag),
        .rd_tag    (bus.rd_tag),
        .rd_ready  (bus.rd_ready),
        .rd_value  (bus.rd_value)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pc_q     <= '0;
            flush_q  <= 1'b0;
            redir_q  <= 1'b0;
            halted_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            pc_q     <= pc_n;
            flush_q  <= flush_n;
            redir_q  <= redir_n;
            halted_q <= halted_n;
            busy_q   <= busy_n;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        pc_n    = pc_q;

        case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_n = FLUSH;
                    pc_n    = pkt.correct_PC;
                    cnt_n   = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_n = REDIRECT;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            REDIRECT: state_n = IDLE;
            HALT:     state_n = HALT;
            default:  state_n = IDLE;
        endcase

        if (halt_ev) begin
            state_n = HALT;
        end

        flush_n  = (state_n == FLUSH);
        redir_n  = (state_n == REDIRECT);
        halted_n = (state_n == HALT);
        busy_n   = (state_n == FLUSH) || (state_n == REDIRECT);
    end

    assign bus.flush_out      = flush_q;
    assign bus.redirect_valid = redir_q;
    assign bus.redirect_pc    = pc_q;
    assign bus.halted         = halted_q;
    assign bus.busy           = busy_q;

endmodule
